fifo_wr_ptr_ctrl: RTL and testbench
===================================

Name: fifo_wr_ptr_ctrl

Overview:
Write-side pointer and flag controller for the dual-clock FIFO. Runs entirely in the write clock domain. Advances the binary write pointer on accepted writes and drives the memory write address/enable. Publishes the Gray-coded write pointer for the read-domain synchronizer. Compares against the already-synchronized read pointer (wq2_rptr) to produce full, almost-full, fill level and overflow indications.

Parameters:
ADDR_WIDTH, 3, memory address width; FIFO depth = 2^ADDR_WIDTH; legal range >= 2
AF_THRESHOLD, 6, level at or above which W_ALMOST_FULL asserts; legal range 1..2^ADDR_WIDTH

Ports:
W_CLK  input  1  write-domain clock, rising edge
W_RST  input  1  synchronous active-high reset
W_INC  input  1  write request from producer
wq2_rptr  input  ADDR_WIDTH+1  Gray read pointer, already double-flopped into W_CLK
w_addr  output  ADDR_WIDTH  memory write address (binary)
W_EN  output  1  memory write enable
w_ptr  output  ADDR_WIDTH+1  Gray write pointer, registered, to read-domain synchronizer
W_FULL  output  1  FIFO full
W_ALMOST_FULL  output  1  level >= AF_THRESHOLD
w_level  output  ADDR_WIDTH+1  conservative occupancy, 0..2^ADDR_WIDTH
W_OVERFLOW  output  1  one-cycle pulse: write attempted while full

Behaviour:
- Reset: W_RST sampled high at a W_CLK edge clears all registers. After that edge: w_ptr=0, w_addr=0, W_FULL=0, W_ALMOST_FULL=0, w_level=0, W_OVERFLOW=0. W_RST has priority over W_INC.
- Internal state: wbin, an (ADDR_WIDTH+1)-bit binary pointer. wgray, the registered Gray pointer driven on w_ptr.
- Write acceptance (combinational):
  - W_EN = W_INC & ~W_FULL.
  - w_addr = wbin[ADDR_WIDTH-1:0].
  - Memory writes at the current edge, at the current address.
- Next pointer:
  - wbin_next = wbin + W_EN, modulo 2^(ADDR_WIDTH+1). Natural wrap, no saturation.
  - wgray_next = wbin_next ^ (wbin_next >> 1).
  - Both are registered at every edge.
  - w_ptr changes at most one bit per cycle. No combinational path from inputs to w_ptr.
- Full:
  - Registered W_FULL <= (wgray_next == {~wq2_rptr[MSB], ~wq2_rptr[MSB-1], wq2_rptr[MSB-2:0]}).
  - Full asserts on the same edge that accepts the last free slot.
  - Full is re-evaluated every cycle even without a write. It deasserts one edge after wq2_rptr advances.
- Level:
  - rbin_sync = Gray-to-binary of wq2_rptr (combinational XOR prefix).
  - Registered w_level <= wbin_next - rbin_sync, modulo 2^(ADDR_WIDTH+1).
  - Level is pessimistic: the read pointer is stale by the synchronizer latency, so occupancy is never under-reported.
- Almost-full: registered W_ALMOST_FULL <= (wbin_next - rbin_sync) >= AF_THRESHOLD.
- Overflow: registered W_OVERFLOW <= W_INC & W_FULL. It is a single-cycle pulse per rejected cycle. A rejected write leaves pointer, address and level unchanged.
- Simultaneous write and read advance in the same cycle: level and full are computed from the new wbin_next and the new wq2_rptr together.
- Reset mid-operation with W_INC=1: the write is not counted in the pointer. W_EN may be high combinationally in that cycle; the memory contents are don't-care after reset.
- Latency: a write appears on w_ptr one W_CLK edge after acceptance.

Decomposition:
- Shared package/include holds:
  - bin2gray and gray2bin functions, parameterized on ADDR_WIDTH+1.
  - Depth constant FIFO_DEPTH = 1<<ADDR_WIDTH.
- These are reused by the read-side controller.
- One sub-module is natural: gray_to_bin, purely combinational, instantiated for wq2_rptr. The read-side block reuses it.

Test Plan:
All scenarios use ADDR_WIDTH=3 and AF_THRESHOLD=6.
1. Reset: hold W_RST=1 for 2 cycles with W_INC=1. Required: w_ptr=0000, w_addr=0, W_FULL=0, w_level=0, W_OVERFLOW=0, no pointer advance.
2. Fill: wq2_rptr=0000, 8 consecutive writes. Required:
   - w_ptr sequence 0001,0011,0010,0110,0111,0101,0100,1100.
   - W_ALMOST_FULL rises with the 6th write.
   - W_FULL=1 and w_level=8 after the 8th write.
3. Overflow: a 9th W_INC while full. Required: W_EN=0, w_ptr stays 1100, w_addr stays 0, W_OVERFLOW=1 for exactly one cycle.
4. Drain release: while full, drive wq2_rptr=0001. Required: next edge W_FULL=0 and w_level=7. One write then gives w_ptr=1101 and W_FULL=1 again.
5. Wrap-around: stream 20 writes with wq2_rptr tracking two entries behind. Required: wbin wraps 1111->0000 (w_ptr 1000->0000), w_level stays 2, no spurious W_FULL.
6. Reset mid-stream: assert W_RST with the FIFO at level 5 and W_INC=1. Required: next edge all outputs return to reset values.

Source files
------------

// File: rtl/fifo_wr_ptr_ctrl_pkg.sv
// Shared pointer-coding helpers for the dual-clock FIFO controllers.
// The functions are width-generic: callers zero-extend into CODE_W and truncate the result.
package fifo_wr_ptr_ctrl_pkg;

   localparam int CODE_W         = 32;
   localparam int DEF_ADDR_WIDTH = 3;
   localparam int FIFO_DEPTH     = 1 << DEF_ADDR_WIDTH;

   function automatic logic [CODE_W-1:0] bin2gray(input logic [CODE_W-1:0] b);
      return b ^ (b >> 1);
   endfunction

   // Zero-extended upper bits leave the prefix XOR of the real bits untouched.
   function automatic logic [CODE_W-1:0] gray2bin(input logic [CODE_W-1:0] g);
      logic [CODE_W-1:0] b;
      b[CODE_W-1] = g[CODE_W-1];
      for (int i = CODE_W-2; i >= 0; i--) begin
         b[i] = b[i+1] ^ g[i];
      end
      return b;
   endfunction

endpackage

// File: rtl/fifo_wr_ptr_ctrl_if.sv
// Write-side bundle between the producer/synchronizer and the write pointer controller.
interface fifo_wr_ptr_ctrl_if #(parameter int ADDR_WIDTH = 3);

   logic                  W_INC;
   logic [ADDR_WIDTH:0]   wq2_rptr;
   logic [ADDR_WIDTH-1:0] w_addr;
   logic                  W_EN;
   logic [ADDR_WIDTH:0]   w_ptr;
   logic                  W_FULL;
   logic                  W_ALMOST_FULL;
   logic [ADDR_WIDTH:0]   w_level;
   logic                  W_OVERFLOW;

   modport master (
      output W_INC, wq2_rptr,
      input  w_addr, W_EN, w_ptr, W_FULL, W_ALMOST_FULL, w_level, W_OVERFLOW
   );

   modport slave (
      input  W_INC, wq2_rptr,
      output w_addr, W_EN, w_ptr, W_FULL, W_ALMOST_FULL, w_level, W_OVERFLOW
   );

endinterface

// File: rtl/fifo_wr_ptr_ctrl_gray_to_bin.sv
// Combinational Gray-to-binary converter, shared by both FIFO pointer controllers.
module fifo_wr_ptr_ctrl_gray_to_bin
   import fifo_wr_ptr_ctrl_pkg::*;
#(
   parameter int W = 4
) (
   input  logic [W-1:0] gray,
   output logic [W-1:0] bin
);

   assign bin = W'(gray2bin(CODE_W'(gray)));

endmodule

// File: rtl/fifo_wr_ptr_ctrl.sv
// Write-domain pointer/flag controller: binary+Gray write pointer, full, almost-full,
// pessimistic fill level and overflow pulse against the synchronized read pointer.
module fifo_wr_ptr_ctrl
   import fifo_wr_ptr_ctrl_pkg::*;
#(
   parameter int ADDR_WIDTH   = DEF_ADDR_WIDTH,
   parameter int AF_THRESHOLD = 6
) (
   input  logic             W_CLK,
   input  logic             W_RST,
   fifo_wr_ptr_ctrl_if.slave wif
);

   localparam int PTR_W = ADDR_WIDTH + 1;
   localparam logic [PTR_W-1:0] AF_TH = PTR_W'(AF_THRESHOLD);

   logic [PTR_W-1:0] wbin;
   logic [PTR_W-1:0] wgray;
   logic [PTR_W-1:0] wbin_next;
   logic [PTR_W-1:0] wgray_next;
   logic [PTR_W-1:0] rbin_sync;
   logic [PTR_W-1:0] level_next;
   logic [PTR_W-1:0] full_cmp;
   logic             wfull;
   logic             walmost_full;
   logic [PTR_W-1:0] wlevel;
   logic             wovf;
   logic             wen;

   fifo_wr_ptr_ctrl_gray_to_bin #(.W(PTR_W)) u_rptr_g2b (
      .gray (wif.wq2_rptr),
      .bin  (rbin_sync)
   );

   assign wen        = wif.W_INC & ~wfull;
   assign wbin_next  = wbin + PTR_W'(wen);
   assign wgray_next = PTR_W'(bin2gray(CODE_W'(wbin_next)));
   assign level_next = wbin_next - rbin_sync;

   // Full when the write pointer is one lap ahead: top two Gray bits inverted, rest equal.
   assign full_cmp = {~wif.wq2_rptr[PTR_W-1], ~wif.wq2_rptr[PTR_W-2], wif.wq2_rptr[PTR_W-3:0]};

   always_ff @(posedge W_CLK) begin
      if (W_RST) begin
         wbin         <= '0;
         wgray        <= '0;
         wfull        <= 1'b0;
         walmost_full <= 1'b0;
         wlevel       <= '0;
         wovf         <= 1'b0;
      end else begin
         wbin         <= wbin_next;
         wgray        <= wgray_next;
         wfull        <= (wgray_next == full_cmp);
         walmost_full <= (level_next >= AF_TH);
         wlevel       <= level_next;
         wovf         <= wif.W_INC & wfull;
      end
   end

   assign wif.W_EN          = wen;
   assign wif.w_addr        = wbin[ADDR_WIDTH-1:0];
   assign wif.w_ptr         = wgray;
   assign wif.W_FULL        = wfull;
   assign wif.W_ALMOST_FULL = walmost_full;
   assign wif.w_level       = wlevel;
   assign wif.W_OVERFLOW    = wovf;

endmodule

// File: tb/tb_fifo_wr_ptr_ctrl.sv
// Directed bench for fifo_wr_ptr_ctrl with an occupancy-count reference model.
module tb_fifo_wr_ptr_ctrl;

   logic W_CLK = 1'b0;
   logic W_RST = 1'b1;
   always #5 W_CLK = ~W_CLK;

   fifo_wr_ptr_ctrl_if #(.ADDR_WIDTH(3)) wif ();

   fifo_wr_ptr_ctrl #(.ADDR_WIDTH(3), .AF_THRESHOLD(6)) dut (
      .W_CLK (W_CLK),
      .W_RST (W_RST),
      .wif   (wif)
   );

   int n_chk  = 0;
   int n_pass = 0;

   // Reference model: total writes accepted and total reads seen, as plain integers.
   int rd_cnt  = 0;
   int m_wr    = 0;
   bit m_full  = 0;
   bit m_af    = 0;
   int m_level = 0;
   bit m_ovf   = 0;
   bit m_valid = 0;

   function automatic logic [3:0] to_gray(input int n);
      logic [3:0] b;
      b = 4'(n % 16);
      return b ^ (b >> 1);
   endfunction

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
   endtask

   always @(posedge W_CLK) begin
      if (W_RST) begin
         m_wr = 0; m_full = 0; m_af = 0; m_level = 0; m_ovf = 0;
         m_valid = 1;
      end else begin
         int occ;
         m_ovf = wif.W_INC && m_full;
         if (wif.W_INC && !m_full) m_wr++;
         occ     = m_wr - rd_cnt;
         m_full  = (occ == 8);
         m_level = occ;
         m_af    = (occ >= 6);
      end
   end

   always @(negedge W_CLK) begin
      if (m_valid) begin
         chk("w_ptr",    32'(wif.w_ptr),         32'(to_gray(m_wr)));
         chk("w_addr",   32'(wif.w_addr),        32'(m_wr % 8));
         chk("W_EN",     32'(wif.W_EN),          32'(wif.W_INC && !m_full));
         chk("W_FULL",   32'(wif.W_FULL),        32'(m_full));
         chk("W_AF",     32'(wif.W_ALMOST_FULL), 32'(m_af));
         chk("w_level",  32'(wif.w_level),       32'(m_level));
         chk("W_OVF",    32'(wif.W_OVERFLOW),    32'(m_ovf));
      end
   end

   task automatic tick();
      @(posedge W_CLK);
      #2;
   endtask

   task automatic drive(input bit inc);
      wif.W_INC    = inc;
      wif.wq2_rptr = to_gray(rd_cnt);
   endtask

   logic [3:0] fill_seq [8] = '{4'b0001, 4'b0011, 4'b0010, 4'b0110,
                                4'b0111, 4'b0101, 4'b0100, 4'b1100};

   initial begin
      // 1: reset held two cycles with a pending write
      W_RST = 1'b1;
      rd_cnt = 0;
      drive(1'b1);
      tick();
      tick();
      chk("rst_w_ptr",   32'(wif.w_ptr),      32'h0);
      chk("rst_w_addr",  32'(wif.w_addr),     32'h0);
      chk("rst_full",    32'(wif.W_FULL),     32'h0);
      chk("rst_level",   32'(wif.w_level),    32'h0);
      chk("rst_ovf",     32'(wif.W_OVERFLOW), 32'h0);
      W_RST = 1'b0;

      // 2: fill eight entries
      for (int i = 0; i < 8; i++) begin
         drive(1'b1);
         tick();
         chk("fill_w_ptr", 32'(wif.w_ptr), 32'(fill_seq[i]));
         chk("fill_af",    32'(wif.W_ALMOST_FULL), (i >= 5) ? 32'h1 : 32'h0);
      end
      chk("fill_full",  32'(wif.W_FULL),  32'h1);
      chk("fill_level", 32'(wif.w_level), 32'h8);

      // 3: write attempted while full
      drive(1'b1);
      #1;
      chk("ovf_w_en", 32'(wif.W_EN), 32'h0);
      tick();
      chk("ovf_pulse", 32'(wif.W_OVERFLOW), 32'h1);
      chk("ovf_w_ptr", 32'(wif.w_ptr),      32'hC);
      chk("ovf_w_addr",32'(wif.w_addr),     32'h0);
      drive(1'b0);
      tick();
      chk("ovf_single", 32'(wif.W_OVERFLOW), 32'h0);

      // 4: one read frees a slot
      rd_cnt = 1;
      drive(1'b0);
      tick();
      chk("drain_full",  32'(wif.W_FULL),  32'h0);
      chk("drain_level", 32'(wif.w_level), 32'h7);
      drive(1'b1);
      tick();
      chk("refill_w_ptr", 32'(wif.w_ptr),  32'hD);
      chk("refill_full",  32'(wif.W_FULL), 32'h1);

      // 5: stream with the reader two entries behind, across the pointer wrap
      rd_cnt = m_wr - 2;
      drive(1'b0);
      tick();
      chk("wrap_pre_level", 32'(wif.w_level), 32'h2);
      for (int i = 0; i < 20; i++) begin
         rd_cnt = m_wr - 1;
         drive(1'b1);
         tick();
         chk("wrap_level", 32'(wif.w_level), 32'h2);
         chk("wrap_full",  32'(wif.W_FULL),  32'h0);
         if (m_wr == 15) chk("wrap_w_ptr_15", 32'(wif.w_ptr), 32'h8);
         if (m_wr == 16) chk("wrap_w_ptr_16", 32'(wif.w_ptr), 32'h0);
      end

      // 6: reset at level five with a write pending
      rd_cnt = m_wr - 5;
      drive(1'b0);
      tick();
      chk("mid_level5", 32'(wif.w_level), 32'h5);
      W_RST  = 1'b1;
      rd_cnt = 0;
      drive(1'b1);
      tick();
      chk("mid_w_ptr",  32'(wif.w_ptr),         32'h0);
      chk("mid_w_addr", 32'(wif.w_addr),        32'h0);
      chk("mid_full",   32'(wif.W_FULL),        32'h0);
      chk("mid_af",     32'(wif.W_ALMOST_FULL), 32'h0);
      chk("mid_level",  32'(wif.w_level),       32'h0);
      chk("mid_ovf",    32'(wif.W_OVERFLOW),    32'h0);
      W_RST = 1'b0;
      drive(1'b1);
      tick();
      chk("post_w_ptr", 32'(wif.w_ptr), 32'h1);
      drive(1'b0);
      tick();
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
